// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with internal two-line buffer, runtime threshold and polarity select.
// Optional magnitude output port mag_out is enabled by defining SOBEL_MAG_OUT_EN.
module sobel_stream #(
    parameter int PIX_W          = 8,
    parameter int LINE_W         = 640,
    parameter int CNT_W          = 10,
    parameter int THRESH_DEFAULT = 280
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W+2:0] thresh_in,
    input  logic             thresh_load,
    input  logic             invert,
`ifdef SOBEL_MAG_OUT_EN
    output logic [PIX_W-1:0] mag_out,
`endif
    output logic [PIX_W-1:0] edge_out,
    output logic             edge_valid,
    output logic             edge_sof
);
    localparam int SW = PIX_W + 3;
    localparam int AW = $clog2(LINE_W);

    logic             sof_in;
    logic [CNT_W-1:0] x_q, y_q, x_d, y_d, cur_x, cur_y;

    assign sof_in = pix_valid & pix_sof;

    // cur_x/cur_y is the position of the pixel on pix_in this cycle
    always_comb begin
        cur_x = sof_in ? '0 : x_q;
        cur_y = sof_in ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (pix_valid) begin
            if (cur_x == CNT_W'(LINE_W - 1)) begin
                x_d = '0;
                y_d = (&cur_y) ? cur_y : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    logic [PIX_W-1:0] lb0_mem [LINE_W];
    logic [PIX_W-1:0] lb1_mem [LINE_W];
    logic [AW-1:0]    lb_addr;
    logic [PIX_W-1:0] row1, row2;
    logic [PIX_W-1:0] win_q [9];

    assign lb_addr = cur_x[AW-1:0];
    assign row1    = lb1_mem[lb_addr];
    assign row2    = lb0_mem[lb_addr];

    // lb1 holds line y-1, lb0 holds line y-2; both indexed by column
    always_ff @(posedge clock) begin
        if (pix_valid) begin
            lb1_mem[lb_addr] <= pix_in;
            lb0_mem[lb_addr] <= row1;
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= row2;
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= row1;
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= pix_in;
        end
    end

    function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [SW-1:0] absv(input logic signed [SW-1:0] v);
        return v[SW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic signed [SW-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [SW-1:0]        ax_q, ay_q, sum_q, thresh_q;
    logic [3:0]           vld_q, sof_q, bdr_q;
    logic                 edge_hit;

    assign gx_d = (sx(win_q[2]) - sx(win_q[0])) + ((sx(win_q[5]) - sx(win_q[3])) <<< 1)
                + (sx(win_q[8]) - sx(win_q[6]));
    assign gy_d = (sx(win_q[0]) - sx(win_q[6])) + ((sx(win_q[1]) - sx(win_q[7])) <<< 1)
                + (sx(win_q[2]) - sx(win_q[8]));

    assign edge_hit = !bdr_q[3] && (sum_q > thresh_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            thresh_q   <= SW'(THRESH_DEFAULT);
            vld_q      <= '0;
            sof_q      <= '0;
            bdr_q      <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            sum_q      <= '0;
            edge_out   <= '0;
            edge_valid <= 1'b0;
            edge_sof   <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (thresh_load)
                thresh_q <= thresh_in;
            vld_q      <= {vld_q[2:0], pix_valid};
            sof_q      <= {sof_q[2:0], sof_in};
            bdr_q      <= {bdr_q[2:0], (cur_x < CNT_W'(2)) || (cur_y < CNT_W'(2))};
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            ax_q       <= absv(gx_q);
            ay_q       <= absv(gy_q);
            sum_q      <= ax_q + ay_q;
            edge_out   <= (edge_hit ^ invert) ? '0 : '1;
            edge_valid <= vld_q[3];
            edge_sof   <= sof_q[3];
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    logic [SW-1:0] quarter;
    assign quarter = sum_q >> 2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            mag_out <= '0;
        else if (bdr_q[3])
            mag_out <= '0;
        else
            mag_out <= (|quarter[SW-1:PIX_W]) ? '1 : quarter[PIX_W-1:0];
    end
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: directed step/flat frames, threshold reload, invert, gapped random frame, mid-line reset.
module tb_sobel_stream;
    localparam int LW = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [10:0] thresh_in = '0;
    logic        thresh_load = 1'b0;
    logic        invert = 1'b0;
    logic [7:0]  edge_out;
    logic        edge_valid;
    logic        edge_sof;
`ifdef SOBEL_MAG_OUT_EN
    logic [7:0]  mag_out;
`endif

    sobel_stream #(.PIX_W(8), .LINE_W(LW), .CNT_W(10), .THRESH_DEFAULT(280)) dut (
        .clock(clock), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .thresh_in(thresh_in), .thresh_load(thresh_load), .invert(invert),
`ifdef SOBEL_MAG_OUT_EN
        .mag_out(mag_out),
`endif
        .edge_out(edge_out), .edge_valid(edge_valid), .edge_sof(edge_sof)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_pass = 0, n_chk = 0;
    int n_in = 0, n_out = 0, t_out = -1;
    int thr_m = 280;
    bit inv_m = 1'b0, gaps = 1'b0, cap_en = 1'b0;
    logic [8:0] exp_q [$];
    logic [7:0] cap_q [$];
    logic [7:0] cap1 [$];
    logic [7:0] img [0:5][0:LW-1];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pop one expected result per presented output
    logic [8:0] mon_e;
    always @(negedge clock) begin
        if (reset_n && edge_valid) begin
            n_out++;
            if (t_out < 0) t_out = cyc;
            if (cap_en) cap_q.push_back(edge_out);
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("edge_out", int'(edge_out), int'(mon_e[7:0]));
                chk("edge_sof", int'(edge_sof), int'(mon_e[8]));
            end
        end
    end

    task automatic drive(input logic [7:0] p, input bit sof, input bit ed);
        if (gaps)
            for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
                @(posedge clock); #1;
            end
        exp_q.push_back({sof, ((ed ^ inv_m) ? 8'h00 : 8'hFF)});
        pix_in = p; pix_sof = sof; pix_valid = 1'b1; n_in++;
        @(posedge clock); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    // Vertical step at column 10: only x=10,11 see the full 4*amp gradient
    task automatic step_rows(input int y0, input int y1, input int amp, input bit sof);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < LW; x++)
                drive((x >= 10) ? 8'(amp) : 8'd0, sof && y == y0 && x == 0,
                      y >= 2 && (x == 10 || x == 11) && 4 * amp > thr_m);
    endtask

    function automatic bit rnd_edge(input int x, input int y);
        int z [9];
        int gx, gy;
        if (x < 2 || y < 2) return 1'b0;
        for (int k = 0; k < 9; k++) z[k] = int'(img[y - 2 + k / 3][x - 2 + k % 3]);
        gx = (z[2] - z[0]) + 2 * (z[5] - z[3]) + (z[8] - z[6]);
        gy = (z[0] - z[6]) + 2 * (z[1] - z[7]) + (z[2] - z[8]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > thr_m;
    endfunction

    task automatic rnd_frame();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < LW; x++)
                drive(img[y][x], y == 0 && x == 0, rnd_edge(x, y));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string nm);
        idle(10);
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_count"}, n_out, n_in);
    endtask

    task automatic load_thr(input int t);
        thresh_in = 11'(t); thresh_load = 1'b1;
        @(posedge clock); #1;
        thresh_load = 1'b0; thr_m = t;
    endtask

    int t_in;
    initial begin
        #12;
        chk("reset_edge_out", int'(edge_out), 0);
        chk("reset_edge_valid", int'(edge_valid), 0);
        chk("reset_edge_sof", int'(edge_sof), 0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // flat frame: every result non-edge; latency from first sample
        t_in = cyc;
        for (int i = 0; i < 4 * LW; i++) drive(8'd100, i == 0, 1'b0);
        drain("flat");
        chk("latency", t_out - t_in, 5);

        step_rows(0, 3, 255, 1'b1);
        drain("step255");
        step_rows(0, 3, 70, 1'b1);
        drain("step70");
        step_rows(0, 3, 71, 1'b1);
        drain("step71");

        // threshold reload and invert changes mid-frame, in input gaps
        load_thr(1019);
        step_rows(0, 2, 255, 1'b1);
        idle(8);
        load_thr(1020);
        step_rows(3, 4, 255, 1'b0);
        idle(8);
        invert = 1'b1; inv_m = 1'b1;
        load_thr(1019);
        step_rows(5, 6, 255, 1'b0);
        drain("reload");
        invert = 1'b0; inv_m = 1'b0;

        // random frame, continuous then gapped; sequences must match
        load_thr(280);
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < LW; x++) img[y][x] = 8'($urandom_range(0, 255));
        cap_en = 1'b1;
        rnd_frame();
        drain("rnd_cont");
        cap1 = cap_q;
        cap_q.delete();
        gaps = 1'b1;
        rnd_frame();
        drain("rnd_gap");
        cap_en = 1'b0; gaps = 1'b0;
        chk("rerun_len", cap_q.size(), cap1.size());
        for (int i = 0; i < cap1.size() && i < cap_q.size(); i++)
            if (cap_q[i] != cap1[i]) chk("rerun_seq", int'(cap_q[i]), int'(cap1[i]));

        // reset mid-line with results in flight
        load_thr(100);
        step_rows(0, 1, 255, 1'b1);
        for (int x = 0; x < 8; x++) drive((x >= 10) ? 8'd255 : 8'd0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_valid", int'(edge_valid), 0);
        chk("mid_reset_out", int'(edge_out), 0);
        chk("mid_reset_sof", int'(edge_sof), 0);
        exp_q.delete();
        n_in = n_out;
        thr_m = 280;
        @(negedge clock); reset_n = 1'b1;
        idle(8);
        chk("no_valid_after_reset", n_out, n_in);
        step_rows(0, 3, 70, 1'b1);
        drain("post_reset70");
        step_rows(0, 3, 71, 1'b1);
        drain("post_reset71");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
